pipeline_ctrl: RTL and testbench

Parametrised hazard and pipeline-control unit for the 5-stage RISC-V core (IF, ID, EX, MEM, WB). It keeps a registered scoreboard of the destination registers held in EX, MEM and WB. From that scoreboard and the ID-stage decode fields it produces the per-stage advance, flush and bubble controls, the EX operand-forwarding selects and the ID write-back bypass. It replaces the single global `pipeline_advance`, adds an optional no-forwarding mode, and keeps saturating stall and flush counters for performance monitoring.

---
 rtl/pipeline_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core: scoreboard of EX/MEM/WB
// destinations, per-stage advance/flush/bubble, EX forwarding, ID bypass, perf counters.
module pipeline_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int FORWARD_EN = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_wr_en,
  input  logic                  id_is_load,
  input  logic                  ex_redirect,
  input  logic                  mem_busy,
  output logic                  advance_f,
  output logic                  flush_d,
  output logic                  bubble_e,
  output logic                  advance_e,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  id_bypass_a,
  output logic                  id_bypass_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = {REG_ADDR_W{1'b0}};
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic src_match(input logic writer, input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] rs, input logic used);
    return writer & used & (rd == rs);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic                  ex_valid_r, ex_wr_en_r, ex_is_load_r;
  logic [REG_ADDR_W-1:0] ex_rd_r, ex_rs1_r, ex_rs2_r;
  logic                  ex_rs1_used_r, ex_rs2_used_r;
  logic                  mem_valid_r, mem_wr_en_r, mem_is_load_r;
  logic [REG_ADDR_W-1:0] mem_rd_r;
  logic                  wb_valid_r, wb_wr_en_r;
  logic [REG_ADDR_W-1:0] wb_rd_r;

  logic ex_writer_s, mem_writer_s, wb_writer_s;
  logic hit_ex_rs1_s, hit_ex_rs2_s, hit_mem_rs1_s, hit_mem_rs2_s;
  logic hz_s, stall_event_s;

  assign ex_writer_s  = ex_valid_r  & ex_wr_en_r  & (ex_rd_r  != ZERO_REG);
  assign mem_writer_s = mem_valid_r & mem_wr_en_r & (mem_rd_r != ZERO_REG);
  assign wb_writer_s  = wb_valid_r  & wb_wr_en_r  & (wb_rd_r  != ZERO_REG);

  assign hit_ex_rs1_s  = src_match(ex_writer_s,  ex_rd_r,  id_rs1, id_rs1_used);
  assign hit_ex_rs2_s  = src_match(ex_writer_s,  ex_rd_r,  id_rs2, id_rs2_used);
  assign hit_mem_rs1_s = src_match(mem_writer_s, mem_rd_r, id_rs1, id_rs1_used);
  assign hit_mem_rs2_s = src_match(mem_writer_s, mem_rd_r, id_rs2, id_rs2_used);

  // Hazard detection: with forwarding only a load in EX can starve the ID consumer
  always_comb begin
    hz_s = 1'b0;
    if (FORWARD_EN != 0) begin
      hz_s = id_valid & ex_is_load_r & (hit_ex_rs1_s | hit_ex_rs2_s);
    end else begin
      hz_s = id_valid & (hit_ex_rs1_s | hit_ex_rs2_s | hit_mem_rs1_s | hit_mem_rs2_s);
    end
  end

  // Stage controls; a taken redirect overrides the hazard stall
  always_comb begin
    advance_e = ~mem_busy;
    advance_f = ~mem_busy & (~hz_s | ex_redirect);
    flush_d   = ~mem_busy & ex_redirect;
    bubble_e  = ~mem_busy & (hz_s | ex_redirect);
  end

  // EX operand forwarding, MEM before WB; a load in MEM has no data yet
  always_comb begin
    fwd_a_sel = FWD_REG;
    fwd_b_sel = FWD_REG;
    if ((FORWARD_EN != 0) && ex_valid_r) begin
      if (src_match(mem_writer_s, mem_rd_r, ex_rs1_r, ex_rs1_used_r) && !mem_is_load_r) begin
        fwd_a_sel = FWD_MEM;
      end else if (src_match(wb_writer_s, wb_rd_r, ex_rs1_r, ex_rs1_used_r)) begin
        fwd_a_sel = FWD_WB;
      end else begin
        fwd_a_sel = FWD_REG;
      end
      if (src_match(mem_writer_s, mem_rd_r, ex_rs2_r, ex_rs2_used_r) && !mem_is_load_r) begin
        fwd_b_sel = FWD_MEM;
      end else if (src_match(wb_writer_s, wb_rd_r, ex_rs2_r, ex_rs2_used_r)) begin
        fwd_b_sel = FWD_WB;
      end else begin
        fwd_b_sel = FWD_REG;
      end
    end else begin
      fwd_a_sel = FWD_REG;
      fwd_b_sel = FWD_REG;
    end
  end

  // Register-file write-then-read in the same cycle
  assign id_bypass_a = id_valid & src_match(wb_writer_s, wb_rd_r, id_rs1, id_rs1_used);
  assign id_bypass_b = id_valid & src_match(wb_writer_s, wb_rd_r, id_rs2, id_rs2_used);

  // Scoreboard shift; everything holds while data memory is busy
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_r    <= 1'b0;
      ex_wr_en_r    <= 1'b0;
      ex_is_load_r  <= 1'b0;
      ex_rd_r       <= ZERO_REG;
      ex_rs1_r      <= ZERO_REG;
      ex_rs2_r      <= ZERO_REG;
      ex_rs1_used_r <= 1'b0;
      ex_rs2_used_r <= 1'b0;
      mem_valid_r   <= 1'b0;
      mem_wr_en_r   <= 1'b0;
      mem_is_load_r <= 1'b0;
      mem_rd_r      <= ZERO_REG;
      wb_valid_r    <= 1'b0;
      wb_wr_en_r    <= 1'b0;
      wb_rd_r       <= ZERO_REG;
    end else if (advance_e) begin
      wb_valid_r    <= mem_valid_r;
      wb_wr_en_r    <= mem_wr_en_r;
      wb_rd_r       <= mem_rd_r;
      mem_valid_r   <= ex_valid_r;
      mem_wr_en_r   <= ex_wr_en_r;
      mem_is_load_r <= ex_is_load_r;
      mem_rd_r      <= ex_rd_r;
      if (bubble_e) begin
        ex_valid_r    <= 1'b0;
        ex_wr_en_r    <= 1'b0;
        ex_is_load_r  <= 1'b0;
        ex_rd_r       <= ZERO_REG;
        ex_rs1_r      <= ZERO_REG;
        ex_rs2_r      <= ZERO_REG;
        ex_rs1_used_r <= 1'b0;
        ex_rs2_used_r <= 1'b0;
      end else begin
        ex_valid_r    <= id_valid;
        ex_wr_en_r    <= id_rd_wr_en;
        ex_is_load_r  <= id_is_load;
        ex_rd_r       <= id_rd;
        ex_rs1_r      <= id_rs1;
        ex_rs2_r      <= id_rs2;
        ex_rs1_used_r <= id_rs1_used;
        ex_rs2_used_r <= id_rs2_used;
      end
    end
  end

  assign stall_event_s = (hz_s & ~ex_redirect) | mem_busy;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (stall_event_s) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (flush_d) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl; drives a forwarding and a
// non-forwarding instance with the same ID stream against an in-bench pipeline model.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
  } ins_t;

  typedef struct packed {
    logic       hz;
    logic       af;
    logic       fd;
    logic       be;
    logic       ae;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       ba;
    logic       bb;
  } exp_t;

  logic clk = 1'b0;
  logic rst, redir, busy;
  ins_t id_i;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // instance 1: forwarding, 16-bit counters; instance 0: no forwarding, 4-bit counters
  logic        af1, fd1, be1, ae1, ba1, bb1;
  logic [1:0]  fa1, fb1;
  logic [15:0] sc1, fc1;
  logic        af0, fd0, be0, ae0, ba0, bb0;
  logic [1:0]  fa0, fb0;
  logic [3:0]  sc0, fc0;

  pipeline_ctrl #(.REG_ADDR_W(5), .FORWARD_EN(1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_i.v), .id_rs1(id_i.rs1), .id_rs2(id_i.rs2),
    .id_rs1_used(id_i.u1), .id_rs2_used(id_i.u2), .id_rd(id_i.rd), .id_rd_wr_en(id_i.wr),
    .id_is_load(id_i.ld), .ex_redirect(redir), .mem_busy(busy),
    .advance_f(af1), .flush_d(fd1), .bubble_e(be1), .advance_e(ae1),
    .fwd_a_sel(fa1), .fwd_b_sel(fb1), .id_bypass_a(ba1), .id_bypass_b(bb1),
    .stall_cnt(sc1), .flush_cnt(fc1));

  pipeline_ctrl #(.REG_ADDR_W(5), .FORWARD_EN(0), .CNT_W(4)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_i.v), .id_rs1(id_i.rs1), .id_rs2(id_i.rs2),
    .id_rs1_used(id_i.u1), .id_rs2_used(id_i.u2), .id_rd(id_i.rd), .id_rd_wr_en(id_i.wr),
    .id_is_load(id_i.ld), .ex_redirect(redir), .mem_busy(busy),
    .advance_f(af0), .flush_d(fd0), .bubble_e(be0), .advance_e(ae0),
    .fwd_a_sel(fa0), .fwd_b_sel(fb0), .id_bypass_a(ba0), .id_bypass_b(bb0),
    .stall_cnt(sc0), .flush_cnt(fc0));

  // reference model: instructions in flight per instance, and counter values
  ins_t m_ex[2], m_mem[2], m_wb[2];
  int   m_sc[2], m_fc[2];
  int   cnt_max[2] = '{15, 65535};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // does an in-flight instruction produce register r that the consumer really reads
  function automatic bit produces(input ins_t p, input logic [4:0] r, input logic used);
    return p.v && p.wr && (p.rd != 5'd0) && (p.rd == r) && used;
  endfunction

  // youngest older producer of a source: MEM result if ready, else WB data, else register
  function automatic logic [1:0] operand_src(input int k, input logic [4:0] r, input logic used);
    if (k == 0 || !m_ex[k].v) return 2'd0;
    if (produces(m_mem[k], r, used)) return m_mem[k].ld ? 2'd0 : 2'd1;
    if (produces(m_wb[k], r, used)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t model_eval(input int k);
    exp_t e;
    bit need;
    if (k == 1) begin
      need = m_ex[k].ld && (produces(m_ex[k], id_i.rs1, id_i.u1) ||
                            produces(m_ex[k], id_i.rs2, id_i.u2));
    end else begin
      need = produces(m_ex[k], id_i.rs1, id_i.u1) || produces(m_ex[k], id_i.rs2, id_i.u2) ||
             produces(m_mem[k], id_i.rs1, id_i.u1) || produces(m_mem[k], id_i.rs2, id_i.u2);
    end
    e.hz = id_i.v && need;
    e.ae = !busy;
    e.af = !busy && (!e.hz || redir);
    e.fd = !busy && redir;
    e.be = !busy && (e.hz || redir);
    e.fa = operand_src(k, m_ex[k].rs1, m_ex[k].u1);
    e.fb = operand_src(k, m_ex[k].rs2, m_ex[k].u2);
    e.ba = id_i.v && produces(m_wb[k], id_i.rs1, id_i.u1);
    e.bb = id_i.v && produces(m_wb[k], id_i.rs2, id_i.u2);
    return e;
  endfunction

  task automatic model_update();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e = model_eval(k);
      if (rst) begin
        m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
        m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        if (((e.hz && !redir) || busy) && m_sc[k] < cnt_max[k]) m_sc[k]++;
        if (e.fd && m_fc[k] < cnt_max[k]) m_fc[k]++;
        if (!busy) begin
          m_wb[k]  = m_mem[k];
          m_mem[k] = m_ex[k];
          m_ex[k]  = e.be ? ins_t'('0) : id_i;
        end
      end
    end
  endtask

  task automatic compare_all();
    exp_t e;
    e = model_eval(1);
    check_val("fwd.advance_f", 32'(af1), 32'(e.af));
    check_val("fwd.flush_d", 32'(fd1), 32'(e.fd));
    check_val("fwd.bubble_e", 32'(be1), 32'(e.be));
    check_val("fwd.advance_e", 32'(ae1), 32'(e.ae));
    check_val("fwd.fwd_a_sel", 32'(fa1), 32'(e.fa));
    check_val("fwd.fwd_b_sel", 32'(fb1), 32'(e.fb));
    check_val("fwd.id_bypass_a", 32'(ba1), 32'(e.ba));
    check_val("fwd.id_bypass_b", 32'(bb1), 32'(e.bb));
    check_val("fwd.stall_cnt", 32'(sc1), 32'(m_sc[1]));
    check_val("fwd.flush_cnt", 32'(fc1), 32'(m_fc[1]));
    e = model_eval(0);
    check_val("nofwd.advance_f", 32'(af0), 32'(e.af));
    check_val("nofwd.flush_d", 32'(fd0), 32'(e.fd));
    check_val("nofwd.bubble_e", 32'(be0), 32'(e.be));
    check_val("nofwd.advance_e", 32'(ae0), 32'(e.ae));
    check_val("nofwd.fwd_a_sel", 32'(fa0), 32'(e.fa));
    check_val("nofwd.fwd_b_sel", 32'(fb0), 32'(e.fb));
    check_val("nofwd.id_bypass_a", 32'(ba0), 32'(e.ba));
    check_val("nofwd.id_bypass_b", 32'(bb0), 32'(e.bb));
    check_val("nofwd.stall_cnt", 32'(sc0), 32'(m_sc[0]));
    check_val("nofwd.flush_cnt", 32'(fc0), 32'(m_fc[0]));
  endtask

  // one clock: check against the model, take the edge, advance the model
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input int rd, input logic wr, input logic ld,
                        input int rs1, input logic u1, input int rs2, input logic u2);
    id_i = '{v: v, rd: 5'(rd), wr: wr, ld: ld, rs1: 5'(rs1), u1: u1, rs2: 5'(rs2), u2: u2};
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redir = 1'b0; busy = 1'b0; id_i = '0;
    for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_sc[k] = 0; m_fc[k] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    // outputs while reset is held, nothing asserted
    check_val("rst.advance_f", 32'(af1 & af0), 32'd1);
    check_val("rst.advance_e", 32'(ae1 & ae0), 32'd1);
    check_val("rst.flush_bubble", 32'({fd1, be1, fd0, be0}), 32'd0);
    check_val("rst.fwd", 32'({fa1, fb1, fa0, fb0}), 32'd0);
    check_val("rst.bypass", 32'({ba1, bb1, ba0, bb0}), 32'd0);
    check_val("rst.cnt", 32'({sc1, fc1, sc0, fc0}), 32'd0);
    tick();
    rst = 1'b0;

    // add x1,x2,x3 ; add x4,x1,x5 with forwarding
    set_id(1'b1, 1, 1'b1, 1'b0, 2, 1'b1, 3, 1'b1);
    tick();
    set_id(1'b1, 4, 1'b1, 1'b0, 1, 1'b1, 5, 1'b1);
    check_val("indep.no_stall", 32'(af1), 32'd1);
    tick();
    nop();
    check_val("indep.fwd_a", 32'(fa1), 32'd1);
    check_val("indep.fwd_b", 32'(fb1), 32'd0);
    tick();

    // lw x6,0(x0) ; add x7,x6,x6
    do_reset();
    set_id(1'b1, 6, 1'b1, 1'b1, 0, 1'b1, 0, 1'b0);
    tick();
    set_id(1'b1, 7, 1'b1, 1'b0, 6, 1'b1, 6, 1'b1);
    check_val("ldu.advance_f", 32'(af1), 32'd0);
    check_val("ldu.bubble_e", 32'(be1), 32'd1);
    tick();
    check_val("ldu.released", 32'(af1), 32'd1);
    tick();
    nop();
    check_val("ldu.fwd_a", 32'(fa1), 32'd2);
    check_val("ldu.fwd_b", 32'(fb1), 32'd2);
    check_val("ldu.stall_cnt", 32'(sc1), 32'd1);
    tick();

    // addi x0,x0,5 ; add x8,x0,x0
    do_reset();
    set_id(1'b1, 0, 1'b1, 1'b0, 0, 1'b1, 0, 1'b0);
    tick();
    set_id(1'b1, 8, 1'b1, 1'b0, 0, 1'b1, 0, 1'b1);
    check_val("x0.no_stall", 32'({af1, af0}), 32'd3);
    tick();
    nop();
    check_val("x0.fwd", 32'({fa1, fb1}), 32'd0);
    tick();

    // redirect in the same cycle as a load-use hazard
    do_reset();
    set_id(1'b1, 6, 1'b1, 1'b1, 0, 1'b1, 0, 1'b0);
    tick();
    set_id(1'b1, 7, 1'b1, 1'b0, 6, 1'b1, 6, 1'b1);
    redir = 1'b1;
    #1;
    check_val("redir.advance_f", 32'(af1), 32'd1);
    check_val("redir.flush_d", 32'(fd1), 32'd1);
    check_val("redir.bubble_e", 32'(be1), 32'd1);
    tick();
    redir = 1'b0;
    nop();
    check_val("redir.flush_cnt", 32'(fc1), 32'd1);
    check_val("redir.stall_cnt", 32'(sc1), 32'd0);
    tick();

    // mem_busy for three cycles with a forward pending
    do_reset();
    set_id(1'b1, 1, 1'b1, 1'b0, 2, 1'b1, 3, 1'b1);
    tick();
    set_id(1'b1, 4, 1'b1, 1'b0, 1, 1'b1, 5, 1'b1);
    tick();
    nop();
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("busy.advances", 32'({af1, ae1}), 32'd0);
      check_val("busy.fwd_hold", 32'(fa1), 32'd1);
      tick();
    end
    busy = 1'b0;
    #1;
    check_val("busy.fwd_after", 32'(fa1), 32'd1);
    check_val("busy.stall_cnt", 32'(sc1), 32'd3);
    tick();

    // back-to-back dependency without forwarding
    do_reset();
    set_id(1'b1, 1, 1'b1, 1'b0, 2, 1'b1, 3, 1'b1);
    tick();
    set_id(1'b1, 4, 1'b1, 1'b0, 1, 1'b1, 5, 1'b1);
    check_val("nf.stall1", 32'(af0), 32'd0);
    tick();
    check_val("nf.stall2", 32'(af0), 32'd0);
    check_val("nf.fwd", 32'({fa0, fb0}), 32'd0);
    tick();
    check_val("nf.go", 32'(af0), 32'd1);
    check_val("nf.bypass", 32'(ba0), 32'd1);
    check_val("nf.stall_cnt", 32'(sc0), 32'd2);
    tick();

    // reset in the middle of that stall
    do_reset();
    set_id(1'b1, 1, 1'b1, 1'b0, 2, 1'b1, 3, 1'b1);
    tick();
    set_id(1'b1, 4, 1'b1, 1'b0, 1, 1'b1, 5, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_val("nfrst.advance_f", 32'(af0), 32'd1);
    check_val("nfrst.cnt", 32'({sc0, fc0}), 32'd0);
    tick();

    // randomized traffic with a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      id_i.v   = ($urandom_range(0, 9) < 8);
      id_i.rd  = 5'($urandom_range(0, 7));
      id_i.wr  = ($urandom_range(0, 3) != 0);
      id_i.ld  = ($urandom_range(0, 3) == 0);
      id_i.rs1 = 5'($urandom_range(0, 7));
      id_i.u1  = ($urandom_range(0, 4) != 0);
      id_i.rs2 = 5'($urandom_range(0, 7));
      id_i.u2  = ($urandom_range(0, 2) != 0);
      redir    = ($urandom_range(0, 9) == 0);
      busy     = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
